dht_reader: RTL and testbench

- Parametrised single-wire humidity/temperature sensor reader; next generation of the current DHT11-only driver.
- Runtime-selectable DHT11/DHT22 framing, clock-frequency independent timing, decoded fixed-point outputs, checksum checking, error codes and enforced re-read cooldown.
- Sits between the board top level, which owns the inout pad as an open-drain buffer, and the display/SPI consumers.

---
 rtl/dht_pkg.sv | 57 +++++
 rtl/dht_us_timer.sv | 87 ++++++++
 rtl/dht_reader.sv | 183 ++++++++++++++++++
 tb/tb_dht_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared types and constants for the single-wire DHT11/DHT22 reader.
// Holds the FSM state encoding, error codes and the frame decode helpers.
package dht_pkg;

    localparam int FRAME_BITS = 40;

    localparam logic MODE_DHT11 = 1'b0;
    localparam logic MODE_DHT22 = 1'b1;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_NO_RESP  = 3'd1;
    localparam logic [2:0] ERR_RESP_TO  = 3'd2;
    localparam logic [2:0] ERR_BIT_TO   = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_WAIT_ACK,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK,
        ST_FINISH
    } state_t;

    typedef struct packed {
        logic [15:0] hum;
        logic [15:0] temp;
    } reading_t;

    function automatic logic checksum_ok(input logic [39:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s == f[7:0];
    endfunction

    // DHT11 carries integer/decimal byte pairs; DHT22 carries x10 words with a sign bit.
    function automatic reading_t decode(input logic mode, input logic [39:0] f);
        reading_t    r;
        logic [15:0] mag;
        logic        neg;
        if (mode == MODE_DHT22) begin
            r.hum = f[39:24];
            mag   = {1'b0, f[22:8]};
            neg   = f[23];
        end else begin
            r.hum = 16'(f[39:32]) * 16'd10 + 16'(f[31:24]);
            mag   = 16'(f[23:16]) * 16'd10 + {9'd0, f[14:8]};
            neg   = f[15];
        end
        r.temp = neg ? -mag : mag;
        return r;
    endfunction

endpackage

// File: rtl/dht_us_timer.sv
// Microsecond phase timer (runs only while busy) and millisecond cooldown
// counter (free running, reloaded at the end of each transaction).
module dht_us_timer
    import dht_pkg::*;
#(
    parameter int DIV         = 50,
    parameter int COOLDOWN_MS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        clr,
    input  logic [17:0] limit,
    output logic [17:0] ticks,
    output logic        hit,
    input  logic        cd_load,
    output logic        cd_done
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [17:0]   ticks_q, ticks_d;
    logic [PW-1:0] cd_pre_q, cd_pre_d;
    logic [9:0]    cd_us_q, cd_us_d;
    logic [15:0]   cd_ms_q, cd_ms_d;

    always_comb begin
        pre_d   = pre_q;
        ticks_d = ticks_q;
        if (clr || !run) begin
            pre_d   = '0;
            ticks_d = '0;
        end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (ticks_q != '1)
                ticks_d = ticks_q + 18'd1;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Reloading also restarts the sub-ms phase so the cooldown is exactly COOLDOWN_MS.
    always_comb begin
        cd_pre_d = cd_pre_q;
        cd_us_d  = cd_us_q;
        cd_ms_d  = cd_ms_q;
        if (cd_load) begin
            cd_pre_d = '0;
            cd_us_d  = '0;
            cd_ms_d  = 16'(COOLDOWN_MS);
        end else if (cd_ms_q != '0) begin
            if (cd_pre_q == PRE_MAX) begin
                cd_pre_d = '0;
                if (cd_us_q == 10'd999) begin
                    cd_us_d = '0;
                    cd_ms_d = cd_ms_q - 16'd1;
                end else begin
                    cd_us_d = cd_us_q + 10'd1;
                end
            end else begin
                cd_pre_d = cd_pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            ticks_q  <= '0;
            cd_pre_q <= '0;
            cd_us_q  <= '0;
            cd_ms_q  <= '0;
        end else begin
            pre_q    <= pre_d;
            ticks_q  <= ticks_d;
            cd_pre_q <= cd_pre_d;
            cd_us_q  <= cd_us_d;
            cd_ms_q  <= cd_ms_d;
        end
    end

    assign ticks   = ticks_q;
    assign hit     = ticks_q >= limit;
    assign cd_done = (cd_ms_q == '0);

endmodule

// File: rtl/dht_reader.sv
// DHT11/DHT22 single-wire reader with decode, checksum, error codes and cooldown.
// Define DHT_AUTO_POLL_EN to re-trigger a read automatically whenever READY is high.
module dht_reader
    import dht_pkg::*;
#(
    parameter int CLK_FREQ_HZ        = 50000000,
    parameter int START_LOW_DHT11_US = 18000,
    parameter int START_LOW_DHT22_US = 1100,
    parameter int TIMEOUT_US         = 200,
    parameter int BIT_THRESH_US      = 48,
    parameter int COOLDOWN_MS        = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        MODE,
    input  logic        START,
    input  logic        DHT_IN,
    output logic        DHT_DRIVE_LOW,
    output logic        BUSY,
    output logic        READY,
    output logic        DONE,
    output logic        VALID,
    output logic [2:0]  ERR_CODE,
    output logic [39:0] RAW,
    output logic [15:0] HUM_X10,
    output logic [15:0] TEMP_X10
);
    localparam int DIV = CLK_FREQ_HZ / 1000000;

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic        mode_q, mode_d;
    logic [39:0] shift_q, shift_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        valid_q, valid_d;
    logic [2:0]  err_q, err_d;
    logic [39:0] raw_q, raw_d;
    logic [15:0] hum_q, hum_d;
    logic [15:0] temp_q, temp_d;

    logic [2:0]  fin_err;
    logic [17:0] ticks, limit;
    logic        tmr_hit, cd_done, ready, start_req, rise, fall, bit_val;
    reading_t    rd;

    dht_us_timer #(
        .DIV         (DIV),
        .COOLDOWN_MS (COOLDOWN_MS)
    ) u_timer (
        .clk     (CLK),
        .rst     (RST),
        .run     (state_q != ST_IDLE),
        .clr     (state_d != state_q),
        .limit   (limit),
        .ticks   (ticks),
        .hit     (tmr_hit),
        .cd_load (state_q == ST_FINISH),
        .cd_done (cd_done)
    );

    // sync_q[1] is the synchronized pad, sync_q[2] its previous value for edge detection.
    assign sync_d = {sync_q[1:0], DHT_IN};
    assign rise   = sync_q[1] & ~sync_q[2];
    assign fall   = ~sync_q[1] & sync_q[2];
    assign ready  = EN && (state_q == ST_IDLE) && cd_done;

`ifdef DHT_AUTO_POLL_EN
    assign start_req = START | ready;
`else
    assign start_req = START;
`endif

    always_comb begin
        limit = 18'(TIMEOUT_US);
        if (state_q == ST_START_LOW)
            limit = (mode_q == MODE_DHT22) ? 18'(START_LOW_DHT22_US) : 18'(START_LOW_DHT11_US);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sync_q    <= 3'b111;
            mode_q    <= MODE_DHT11;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= ERR_OK;
            raw_q     <= '0;
            hum_q     <= '0;
            temp_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            raw_q     <= raw_d;
            hum_q     <= hum_d;
            temp_q    <= temp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fin_err   = ERR_OK;
        mode_d    = mode_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        bit_val   = ticks >= 18'(BIT_THRESH_US);
        case (state_q)
            ST_IDLE: if (start_req && ready) begin
                state_d   = ST_START_LOW;
                mode_d    = MODE;
                bit_cnt_d = '0;
            end
            ST_START_LOW: if (tmr_hit) state_d = ST_WAIT_ACK;
            ST_WAIT_ACK:
                if (fall) state_d = ST_RESP_LOW;
                else if (tmr_hit) begin state_d = ST_FINISH; fin_err = ERR_NO_RESP; end
            ST_RESP_LOW:
                if (rise) state_d = ST_RESP_HIGH;
                else if (tmr_hit) begin state_d = ST_FINISH; fin_err = ERR_RESP_TO; end
            ST_RESP_HIGH:
                if (fall) state_d = ST_BIT_LOW;
                else if (tmr_hit) begin state_d = ST_FINISH; fin_err = ERR_RESP_TO; end
            ST_BIT_LOW:
                if (rise) state_d = ST_BIT_HIGH;
                else if (tmr_hit) begin state_d = ST_FINISH; fin_err = ERR_BIT_TO; end
            ST_BIT_HIGH:
                if (fall) begin
                    shift_d   = {shift_q[38:0], bit_val};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? ST_CHECK : ST_BIT_LOW;
                end else if (tmr_hit) begin
                    state_d = ST_FINISH;
                    fin_err = ERR_BIT_TO;
                end
            ST_CHECK: begin
                state_d = ST_FINISH;
                fin_err = checksum_ok(shift_q) ? ERR_OK : ERR_CHECKSUM;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // FINISH is left alone so results and DONE always appear together.
        if (!EN && state_q != ST_FINISH)
            state_d = ST_IDLE;
    end

    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        raw_d   = raw_q;
        hum_d   = hum_q;
        temp_d  = temp_q;
        rd      = decode(mode_q, shift_q);
        if (state_d == ST_FINISH && state_q != ST_FINISH) begin
            err_d   = fin_err;
            valid_d = (fin_err == ERR_OK);
            if (fin_err == ERR_OK) begin
                raw_d  = shift_q;
                hum_d  = rd.hum;
                temp_d = rd.temp;
            end
        end
    end

    always_comb begin
        DHT_DRIVE_LOW = (state_q == ST_START_LOW);
        BUSY          = (state_q != ST_IDLE);
        READY         = ready;
        DONE          = (state_q == ST_FINISH);
        VALID         = valid_q;
        ERR_CODE      = err_q;
        RAW           = raw_q;
        HUM_X10       = hum_q;
        TEMP_X10      = temp_q;
    end

endmodule

// File: tb/tb_dht_reader.sv
// Scoreboard bench for dht_reader: a behavioural sensor drives the pad, a monitor
// checks every DONE against expectations queued when each read is started.
`timescale 1ns/1ps
module tb_dht_reader;
    localparam int CLK_HALF = 250;     // 2 MHz clock -> 1 us tick every 2 cycles
    localparam int US       = 1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic        MODE = 1'b0;
    logic        START = 1'b0;
    logic        sens_low = 1'b0;
    logic        DHT_IN;
    logic        DHT_DRIVE_LOW, BUSY, READY, DONE, VALID;
    logic [2:0]  ERR_CODE;
    logic [39:0] RAW;
    logic [15:0] HUM_X10, TEMP_X10;

    assign DHT_IN = ~(DHT_DRIVE_LOW | sens_low);

    always #CLK_HALF CLK = ~CLK;

    dht_reader #(
        .CLK_FREQ_HZ        (2000000),
        .START_LOW_DHT11_US (300),
        .START_LOW_DHT22_US (100),
        .TIMEOUT_US         (200),
        .BIT_THRESH_US      (48),
        .COOLDOWN_MS        (1)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .EN            (EN),
        .MODE          (MODE),
        .START         (START),
        .DHT_IN        (DHT_IN),
        .DHT_DRIVE_LOW (DHT_DRIVE_LOW),
        .BUSY          (BUSY),
        .READY         (READY),
        .DONE          (DONE),
        .VALID         (VALID),
        .ERR_CODE      (ERR_CODE),
        .RAW           (RAW),
        .HUM_X10       (HUM_X10),
        .TEMP_X10      (TEMP_X10)
    );

    typedef struct packed {
        logic [2:0]  err;
        logic        valid;
        logic [39:0] raw;
        logic [15:0] hum;
        logic [15:0] temp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    time  done_time = 0;
    logic drive_at_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input time act, input time lo, input time hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0t, expected %0t..%0t", name, act, lo, hi);
        end
    endtask

    function automatic exp_t mk_exp(input logic [2:0] e, input logic v, input logic [39:0] r,
                                    input logic [15:0] h, input logic [15:0] t);
        exp_t x;
        x.err = e; x.valid = v; x.raw = r; x.hum = h; x.temp = t;
        return x;
    endfunction

    always @(negedge CLK) begin
        if (!RST && DONE) begin
            done_cnt++;
            done_time     = $time;
            drive_at_done = DHT_DRIVE_LOW;
            $display("txn %0d @%0t: err=%0d valid=%0b raw=%010h hum=%0d temp=%0d",
                     done_cnt, $time, ERR_CODE, VALID, RAW, HUM_X10, $signed(TEMP_X10));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: DONE seen with no pending read");
            end else begin
                mon_e = exp_q.pop_front();
                check("err_code", 64'(ERR_CODE), 64'(mon_e.err));
                check("valid",    64'(VALID),    64'(mon_e.valid));
                check("raw",      64'(RAW),      64'(mon_e.raw));
                check("hum_x10",  64'(HUM_X10),  64'(mon_e.hum));
                check("temp_x10", 64'(TEMP_X10), 64'(mon_e.temp));
            end
        end
    end

    task automatic pulse_start(input logic m);
        @(negedge CLK);
        MODE  = m;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int max_cyc);
        int n = 0;
        while (!READY && n < max_cyc) begin @(negedge CLK); n++; end
        checks++;
        if (!READY) begin
            errors++;
            $display("FAIL %s: READY got 0 after %0d cycles, expected 1", name, max_cyc);
        end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while (BUSY && n < max_cyc) begin @(negedge CLK); n++; end
        checks++;
        if (BUSY) begin
            errors++;
            $display("FAIL %s: BUSY got 1 after %0d cycles, expected 0", name, max_cyc);
        end
    endtask

    // Sensor: waits for the host start pulse, then answers (unless silent).
    // abort_bit >= 0 drops EN just before that bit is sent.
    task automatic sensor(input logic [39:0] frame, input bit silent, input int abort_bit,
                          output time low_len);
        int  n;
        time t0;
        low_len = 0;
        n = 0;
        while (!DHT_DRIVE_LOW && n < 4000) begin @(negedge CLK); n++; end
        if (!DHT_DRIVE_LOW) begin
            checks++; errors++;
            $display("FAIL start_pulse: DHT_DRIVE_LOW got 0, expected 1");
            return;
        end
        t0 = $time;
        n = 0;
        while (DHT_DRIVE_LOW && n < 4000) begin @(negedge CLK); n++; end
        if (DHT_DRIVE_LOW) begin
            checks++; errors++;
            $display("FAIL start_release: DHT_DRIVE_LOW got 1, expected 0");
            return;
        end
        low_len = $time - t0;
        if (silent) return;
        #(20*US); sens_low = 1'b1;
        #(80*US); sens_low = 1'b0;
        #(80*US);
        for (int i = 0; i < 40; i++) begin
            if (i == abort_bit) begin
                EN = 1'b0;
                return;
            end
            sens_low = 1'b1;
            #(30*US);
            sens_low = 1'b0;
            #((frame[39-i] ? 60 : 20) * US);
        end
        sens_low = 1'b1;
        #(5*US);
        sens_low = 1'b0;
    endtask

    initial begin
        #(40_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time lt;
        time rel_t;
        int  dc;
        RST = 1'b1;
        EN  = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_drive",  64'(DHT_DRIVE_LOW), 64'd0);
        check("rst_busy",   64'(BUSY),     64'd0);
        check("rst_done",   64'(DONE),     64'd0);
        check("rst_valid",  64'(VALID),    64'd0);
        check("rst_err",    64'(ERR_CODE), 64'd0);
        check("rst_raw",    64'(RAW),      64'd0);
        check("rst_hum",    64'(HUM_X10),  64'd0);
        check("rst_temp",   64'(TEMP_X10), 64'd0);
        check("rst_ready",  64'(READY),    64'd1);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // DHT11: 55% / 25 C; start pulse 300 us plus at most a cycle
        exp_q.push_back(mk_exp(3'd0, 1'b1, 40'h3700190050, 16'd550, 16'd250));
        pulse_start(1'b0);
        sensor(40'h3700190050, 1'b0, -1, lt);
        check_range("dht11_start_low", lt, 299*US, 301*US);
        wait_idle("dht11_idle", 2000);

        // START 10 us after DONE is ignored; READY returns by COOLDOWN_MS+1
        while ($time < done_time + 10*US) @(negedge CLK);
        check("cooldown_ready_low", 64'(READY), 64'd0);
        pulse_start(1'b1);
        repeat (4) @(negedge CLK);
        check("cooldown_start_ignored", 64'(BUSY), 64'd0);
        while ($time < done_time + 2000*US) @(negedge CLK);
        check("cooldown_ready_again", 64'(READY), 64'd1);

        // DHT22: 65.8% / -1.6 C
        exp_q.push_back(mk_exp(3'd0, 1'b1, 40'h0292801024, 16'd658, 16'hFFF0));
        pulse_start(1'b1);
        sensor(40'h0292801024, 1'b0, -1, lt);
        check_range("dht22_start_low", lt, 99*US, 101*US);
        wait_idle("dht22_idle", 2000);

        // Silent sensor: ERR 1 about 200 us after release, previous values kept
        wait_ready("noresp_ready", 4000);
        exp_q.push_back(mk_exp(3'd1, 1'b0, 40'h0292801024, 16'd658, 16'hFFF0));
        pulse_start(1'b1);
        sensor(40'h0, 1'b1, -1, lt);
        rel_t = $time;
        wait_idle("noresp_idle", 1000);
        check_range("noresp_latency", done_time - rel_t, 199*US, 202*US);
        check("noresp_drive", 64'(drive_at_done), 64'd0);

        // Checksum byte zeroed: ERR 4, RAW stays at the last good frame
        wait_ready("cksum_ready", 4000);
        exp_q.push_back(mk_exp(3'd4, 1'b0, 40'h0292801024, 16'd658, 16'hFFF0));
        pulse_start(1'b1);
        sensor(40'h0292801000, 1'b0, -1, lt);
        wait_idle("cksum_idle", 2000);

        // EN dropped at bit 20: back to IDLE, no DONE, no cooldown load
        wait_ready("abort_ready", 4000);
        dc = done_cnt;
        pulse_start(1'b1);
        sensor(40'h0292801024, 1'b0, 20, lt);
        repeat (2) @(negedge CLK);
        check("abort_busy",  64'(BUSY),          64'd0);
        check("abort_drive", 64'(DHT_DRIVE_LOW), 64'd0);
        check("abort_raw",   64'(RAW),           64'h0292801024);
        check("abort_err",   64'(ERR_CODE),      64'd4);
        #(300*US);
        check("abort_no_done", 64'(done_cnt), 64'(dc));
        EN = 1'b1;
        @(negedge CLK);
        check("abort_no_cooldown", 64'(READY), 64'd1);

        // Asynchronous reset during START_LOW releases the line at once
        wait_ready("rst_mid_ready", 4000);
        pulse_start(1'b0);
        repeat (20) @(negedge CLK);
        check("rst_mid_pre_drive", 64'(DHT_DRIVE_LOW), 64'd1);
        #100;
        RST = 1'b1;
        #1;
        check("rst_mid_drive", 64'(DHT_DRIVE_LOW), 64'd0);
        check("rst_mid_busy",  64'(BUSY),  64'd0);
        check("rst_mid_valid", 64'(VALID), 64'd0);
        check("rst_mid_raw",   64'(RAW),   64'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
